// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the cipher / inv_cipher blocks.
// Contents: round/key constants, forward and inverse S-box tables, GF(2^8)
// helpers, and the state transforms used by the inverse round datapath.
// State packing: byte j sits at [8j+7:8j], byte 4c+r is row r, column c.
// Round-key packing: word c at [32c+31:32c], its MSB byte belongs to row 0.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } ic_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-reduce multiply; with a constant b the unused partial
    // products fold away.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates right by r: out[r][c] = s[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int j = 0; j < 16; j++)
            o[8*j +: 8] = INV_SBOX[s[8*j +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                   ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction

    // Key words are big-endian by row: row 0 takes the word's MSB byte.
    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = s[32*c + 8*r +: 8] ^ rk[32*c + 24 - 8*r +: 8];
        return o;
    endfunction

endpackage

// File: rtl/inv_cipher_round.sv
// ---------------------------------------------------------------------------
// inv_round
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// Ports:
//   i_st   [127:0] current state
//   i_rk   [127:0] round key for this round
//   i_last         final round, skips InvMixColumns
//   o_st   [127:0] next state
// ---------------------------------------------------------------------------
module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_st,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output logic [127:0] o_st
);

    logic [127:0] w_ark;

    assign w_ark = add_round_key(inv_sub_bytes(inv_shift_rows(i_st)), i_rk);
    assign o_st  = i_last ? w_ark : inv_mix_columns(w_ark);

endmodule

// File: rtl/inv_cipher.sv
// ---------------------------------------------------------------------------
// inv_cipher
// Iterative AES-128 decryptor, one round per clock, valid/ready on both sides.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in       [127:0]   ciphertext
//   w        [1407:0]  expanded key (44 words), held stable per block
//   in_valid/in_ready  input handshake
//   out      [127:0]   plaintext
//   out_valid/out_ready output handshake
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for in_valid; accepting edge applies rk10
// S_ROUND | rnd 9..1 full inverse rounds, rnd 0 final round into out
// S_DONE  | out/out_valid held until out_ready
// ---------------------------------------------------------------------------
module inv_cipher
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  in,
    input  logic [1407:0] w,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [127:0]  out,
    output logic          out_valid,
    input  logic          out_ready
);

    ic_state_e    r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_st;
    logic [127:0] r_out;
    logic         r_out_valid;
    logic         r_in_ready;

    logic [127:0] w_rk;
    logic [127:0] w_round;
    logic         w_last;

    // Round-key select; rnd never leaves 0..9 so the guard keeps the mux
    // to the 11 real round keys.
    always_comb begin
        w_rk = '0;
        for (int r = 0; r <= NR; r++)
            if (r_rnd == 4'(r)) w_rk = w[128*r +: 128];
    end

    assign w_last = (r_rnd == 4'd0);

    inv_round u_round (
        .i_st   (r_st),
        .i_rk   (w_rk),
        .i_last (w_last),
        .o_st   (w_round)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rnd       <= '0;
            r_st        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st       <= add_round_key(in, w[128*NR +: 128]);
                        r_rnd      <= 4'(NR - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (w_last) begin
                        r_out       <= w_round;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_st  <= w_round;
                        r_rnd <= r_rnd - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
